ahb_wb_bridge: RTL and testbench
================================

# ahb_wb_bridge

Parametrised AHB-Lite slave to Wishbone classic master bridge for peripheral subsystems such as the SD card controller. It supports configurable data width, address window and Wishbone timeout, and adds byte-lane generation, alignment and window checking, a two-cycle AHB ERROR response and Wishbone error propagation. It sits between the AHB peripheral bus and a single Wishbone slave register file.

## Interface
- DATA_W, 32: data width, 32 or 64.
- ADDR_W, 8: Wishbone address width, taken from haddr[ADDR_W-1:0].
- SEL_BIT, 28: haddr bit that must be 1 for an in-window access.
- TIMEOUT, 255: max Wishbone wait cycles; 0 disables the timeout.
- clk  in  1  bus clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- haddr  in  32  AHB address.
- hwdata  in  DATA_W  AHB write data, valid in the data phase.
- hwrite  in  1  1 means write.
- hsize  in  3  transfer size.
- hburst  in  3  burst type; ignored.
- hsel  in  1  slave select.
- htrans  in  2  IDLE, BUSY, NONSEQ or SEQ.
- hready  in  1  bus ready.
- hprot  in  4  ignored.
- hrdata  out  DATA_W  read data.
- hresp  out  1  1 means ERROR.
- hreadyout  out  1  slave ready.
- wb_adr_o  out  ADDR_W  Wishbone address.
- wb_dat_o  out  DATA_W  Wishbone write data.
- wb_dat_i  in  DATA_W  Wishbone read data.
- wb_sel_o  out  DATA_W/8  byte enables.
- wb_we_o, wb_cyc_o, wb_stb_o  out  1 each  Wishbone controls.
- wb_ack_i, wb_err_i  in  1 each  Wishbone termination.

## Operation
- **Address phase accept:** hsel & hready & htrans[1] at a rising edge. At that edge haddr, hwrite and hsize are registered.
- **Transfers with no Wishbone access:** BUSY and IDLE get an OKAY zero-wait response. hburst is ignored; every beat, SEQ included, is an independent Wishbone cycle.
- **Checks at accept.** Any failure goes straight to ERR1 with no Wishbone cycle. The checks are:
  - hsize > log2(DATA_W/8);
  - haddr not aligned to the transfer size;
  - haddr[SEL_BIT] = 0.
- **Byte enables:** wb_sel_o is decoded from hsize and haddr[log2(DATA_W/8)-1:0], little-endian. Examples for DATA_W=32: byte at addr 0x..2 gives 4'b0100, halfword at 0x..2 gives 4'b1100, word gives 4'b1111.
- **FSM states:** IDLE, WDATA, WBREQ, ERR1, ERR2.
- **IDLE transitions** on an accepted transfer:
  - read: go to WBREQ;
  - write: go to WDATA;
  - check failure: go to ERR1.
- **WDATA:** capture hwdata into wb_dat_o, then go to WBREQ.
- **WBREQ:** cyc, stb and the outputs are held stable until termination.
  - wb_ack_i: drop cyc/stb next cycle and go to IDLE. On a read, wb_dat_i is registered into hrdata.
  - wb_err_i (err wins if both are asserted): go to ERR1.
  - Timeout counter reaches TIMEOUT: drop cyc/stb and go to ERR1.
- **ERR1:** hreadyout=0, hresp=1.
- **ERR2:** hreadyout=1, hresp=1, then go to IDLE.
- **hrdata:** 0 in ERR1 and ERR2, and after writes it holds its last value.
- **Timeout counter:** log2(TIMEOUT+1) bits. It clears on WBREQ entry and increments each WBREQ cycle without ack or err.

## Timing
- **Reset values:**
  - hreadyout=1;
  - hresp=0;
  - hrdata=0;
  - all wb_* outputs 0;
  - state IDLE.
- rst_n low mid-transaction clears cyc/stb asynchronously, with no completion on either bus.
- hreadyout is 0 in WDATA, WBREQ and ERR1, and 1 otherwise.
- An address phase is accepted only in IDLE, ERR2, or the hreadyout=1 cycle ending WBREQ. That is the pipelined next address.
- **Read latency.** Address phase in cycle A gives stb in A+1. A combinational ack in A+1 gives hreadyout=1 with valid hrdata in A+2. Each extra slave wait cycle adds 1.
- **Write latency.** Address phase in A gives WDATA in A+1 (hwdata sampled at the end of A+1) and stb in A+2. Ack in A+2 gives hreadyout=1 in A+3.
- **Error latency.** A check failure in A gives ERR1 in A+1 and ERR2 in A+2. A Wishbone error or timeout in cycle N gives ERR1 in N+1 and ERR2 in N+2.
- **Timeout boundary:** an ack arriving in the same cycle the counter hits TIMEOUT counts as success.
- **Back-to-back:** a new NONSEQ accepted in the completing cycle restarts the FSM with no idle gap.

## Test plan
- **Aligned read:** read word 0x1000_0010, slave acks 0 wait with 0xDEADBEEF -> stb in A+1, wb_adr_o=0x10, sel=4'b1111, hrdata=0xDEADBEEF with hreadyout=1 in A+2.
- **Byte write:** write byte 0x1000_0003, hwdata=0xAB00_0000, 2 slave wait states -> wb_sel_o=4'b1000, wb_dat_o=0xAB00_0000, we=1, hreadyout=1 in A+5.
- **Window miss:** read 0x0000_0004 -> no cyc, ERR1 then ERR2 (hresp=1 for 2 cycles, hreadyout 0 then 1).
- **Slave errors:** unaligned halfword at 0x1000_0001 -> two-cycle ERROR. wb_err_i during a read -> two-cycle ERROR, hrdata=0.
- **Timeout:** TIMEOUT=4, slave never acks -> cyc/stb drop after 4 stb cycles, then ERROR. A following read with a prompt ack succeeds.
- **Reset and pipelining:**
  - rst_n low during WBREQ -> cyc/stb low immediately, hreadyout=1.
  - After reset, back-to-back NONSEQ read, write, read -> three Wishbone cycles in order, no dropped beat.

Source files
------------

// File: rtl/ahb_wb_bridge_if.sv
// Bus bundle between an AHB-Lite master / Wishbone slave environment and the bridge.
// The slave modport is the bridge's view; the master modport is the environment's view.
interface ahb_wb_bridge_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  // AHB-Lite side
  logic [31:0]         haddr;
  logic [DATA_W-1:0]   hwdata;
  logic                hwrite;
  logic [2:0]          hsize;
  logic [2:0]          hburst;
  logic                hsel;
  logic [1:0]          htrans;
  logic                hready;
  logic [3:0]          hprot;
  logic [DATA_W-1:0]   hrdata;
  logic                hresp;
  logic                hreadyout;

  // Wishbone classic side
  logic [ADDR_W-1:0]   wb_adr_o;
  logic [DATA_W-1:0]   wb_dat_o;
  logic [DATA_W-1:0]   wb_dat_i;
  logic [DATA_W/8-1:0] wb_sel_o;
  logic                wb_we_o;
  logic                wb_cyc_o;
  logic                wb_stb_o;
  logic                wb_ack_i;
  logic                wb_err_i;

  modport slave (
    input  haddr, hwdata, hwrite, hsize, hburst, hsel, htrans, hready, hprot,
    output hrdata, hresp, hreadyout,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport master (
    output haddr, hwdata, hwrite, hsize, hburst, hsel, htrans, hready, hprot,
    input  hrdata, hresp, hreadyout,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/ahb_wb_bridge.sv
// AHB-Lite slave to Wishbone classic master bridge. One Wishbone cycle per accepted
// AHB beat, with size/alignment/window checks, byte-lane generation, a Wishbone
// timeout and a two-cycle AHB ERROR response.
module ahb_wb_bridge #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned SEL_BIT = 28,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  ahb_wb_bridge_if.slave bus
);

  localparam int unsigned SelW      = DATA_W / 8;
  localparam int unsigned OffW      = $clog2(SelW);
  localparam int unsigned CntW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TimeoutEn = (TIMEOUT != 0);
  localparam logic [2:0]  MaxSize   = 3'(OffW);
  // Last counter value before it would reach TIMEOUT; a cycle without ack here times out.
  localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {StIdle, StWdata, StWbreq, StErr1, StErr2} state_e;

  state_e            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [OffW-1:0]   off;
  logic [OffW-1:0]   align_mask;
  logic [SelW-1:0]   size_mask;
  logic [SelW-1:0]   sel_dec;
  logic              accept;
  logic              chk_fail;
  logic              timeout_hit;

  assign off    = bus.haddr[OffW-1:0];
  assign accept = bus.hsel & bus.hready & bus.htrans[1];

  // Decode transfer size into a lane mask and an offset alignment mask.
  always_comb begin
    size_mask  = '0;
    align_mask = '0;
    for (int b = 0; b < int'(SelW); b++) begin
      size_mask[b] = (b < (1 << int'(bus.hsize)));
    end
    for (int i = 0; i < int'(OffW); i++) begin
      align_mask[i] = (i < int'(bus.hsize));
    end
  end

  assign sel_dec     = size_mask << off;
  assign chk_fail    = (bus.hsize > MaxSize) | (|(off & align_mask)) | ~bus.haddr[SEL_BIT];
  assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

  // Next-state and datapath update for the transfer FSM.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StErr2: begin
        state_d = StIdle;
        if (accept) begin
          if (chk_fail) begin
            state_d = StErr1;
            rdata_d = '0;
          end else begin
            adr_d = bus.haddr[ADDR_W-1:0];
            we_d  = bus.hwrite;
            sel_d = sel_dec;
            if (bus.hwrite) begin
              state_d = StWdata;
            end else begin
              state_d = StWbreq;
              cyc_d   = 1'b1;
              cnt_d   = '0;
            end
          end
        end
      end
      StWdata: begin
        dat_d   = bus.hwdata;
        state_d = StWbreq;
        cyc_d   = 1'b1;
        cnt_d   = '0;
      end
      StWbreq: begin
        if (bus.wb_err_i) begin
          cyc_d   = 1'b0;
          rdata_d = '0;
          state_d = StErr1;
        end else if (bus.wb_ack_i) begin
          cyc_d   = 1'b0;
          state_d = StIdle;
          if (!we_q) begin
            rdata_d = bus.wb_dat_i;
          end
        end else if (timeout_hit) begin
          cyc_d   = 1'b0;
          rdata_d = '0;
          state_d = StErr1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StErr1: begin
        state_d = StErr2;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset also kills any Wishbone cycle in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.hreadyout = ~((state_q == StWdata) | (state_q == StWbreq) | (state_q == StErr1));
  assign bus.hresp     = (state_q == StErr1) | (state_q == StErr2);
  assign bus.hrdata    = rdata_q;
  assign bus.wb_cyc_o  = cyc_q;
  assign bus.wb_stb_o  = cyc_q;
  assign bus.wb_we_o   = we_q;
  assign bus.wb_adr_o  = adr_q;
  assign bus.wb_sel_o  = sel_q;
  assign bus.wb_dat_o  = dat_q;

  // Burst type, protection and upper address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{bus.hburst, bus.hprot, bus.htrans[0], bus.haddr};

endmodule

// File: tb/tb_ahb_wb_bridge.sv
// Randomised bench for ahb_wb_bridge: an AHB master task and a Wishbone slave process,
// with expected results from a per-transfer outcome model.
module tb_ahb_wb_bridge;

  localparam int unsigned TO = 4;

  logic clk;
  logic rst_n;

  ahb_wb_bridge_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  ahb_wb_bridge #(
    .DATA_W (32),
    .ADDR_W (8),
    .SEL_BIT(28),
    .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.hready = bus.hreadyout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wishbone slave behaviour for the current transfer, set by the master task.
  int          sl_waits = 0;
  bit          sl_err   = 0;
  logic [31:0] sl_rdata = '0;
  int          sl_total = 0;
  int          unstable = 0;
  logic [7:0]  rec_adr;
  logic [3:0]  rec_sel;
  logic        rec_we;
  logic [31:0] rec_dat;

  // Model of the last value AHB hrdata should hold.
  logic [31:0] exp_hrdata = '0;

  initial begin
    int cur;
    cur = 0;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (bus.wb_cyc_o && bus.wb_stb_o) begin
        if (cur == 0) begin
          rec_adr = bus.wb_adr_o;
          rec_sel = bus.wb_sel_o;
          rec_we  = bus.wb_we_o;
          rec_dat = bus.wb_dat_o;
        end else if (rec_adr !== bus.wb_adr_o || rec_sel !== bus.wb_sel_o ||
                     rec_we !== bus.wb_we_o || rec_dat !== bus.wb_dat_o) begin
          unstable++;
        end
        sl_total++;
        bus.wb_ack_i = !sl_err && (cur == sl_waits);
        bus.wb_err_i = sl_err && (cur == sl_waits);
        bus.wb_dat_i = (cur == sl_waits) ? sl_rdata : $urandom;
        cur++;
      end else begin
        cur = 0;
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
      end
    end
  end

  // One AHB beat, starting at a negedge in its address-phase cycle; returns at the
  // negedge where hreadyout ends the transfer.
  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                         input logic [31:0] wdata, input int waits, input bit err,
                         input logic [31:0] rdata);
    bit         chk_fail;
    bit         exp_err;
    int         stb_first, done_exp, n_stb_exp, k;
    logic       prev_hresp;
    logic [3:0] exp_sel;
    chk_fail = (size > 3'd2) || ((addr % (32'd1 << size)) != 0) || (addr[28] == 1'b0);
    exp_sel  = '0;
    if (chk_fail) begin
      exp_err   = 1;
      done_exp  = 2;
      n_stb_exp = 0;
    end else begin
      exp_sel   = 4'(((1 << (1 << size)) - 1) << addr[1:0]);
      stb_first = wr ? 2 : 1;
      if (waits < int'(TO)) begin
        exp_err   = err;
        done_exp  = stb_first + waits + (err ? 2 : 1);
        n_stb_exp = waits + 1;
      end else begin
        exp_err   = 1;
        done_exp  = stb_first + int'(TO) + 1;
        n_stb_exp = int'(TO);
      end
    end
    if (exp_err) exp_hrdata = '0;
    else if (!wr) exp_hrdata = rdata;

    sl_waits   = waits;
    sl_err     = err;
    sl_rdata   = rdata;
    sl_total   = 0;
    bus.hsel   = 1'b1;
    bus.htrans = 2'($urandom_range(2, 3));
    bus.haddr  = addr;
    bus.hwrite = wr;
    bus.hsize  = size;
    bus.hburst = 3'($urandom);
    bus.hprot  = 4'($urandom);
    @(negedge clk);
    k          = 1;
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.hwdata = wdata;
    prev_hresp = 1'b0;
    while (bus.hreadyout !== 1'b1 && k < 60) begin
      prev_hresp = bus.hresp;
      @(negedge clk);
      k++;
    end
    check_eq("latency", 64'(k), 64'(done_exp));
    check_eq("hresp", 64'(bus.hresp), 64'(exp_err));
    if (exp_err) check_eq("err1_hresp", 64'(prev_hresp), 64'd1);
    check_eq("hrdata", 64'(bus.hrdata), 64'(exp_hrdata));
    check_eq("stb_cycles", 64'(sl_total), 64'(n_stb_exp));
    if (!chk_fail) begin
      check_eq("wb_adr", 64'(rec_adr), 64'(addr[7:0]));
      check_eq("wb_sel", 64'(rec_sel), 64'(exp_sel));
      check_eq("wb_we", 64'(rec_we), 64'(wr));
      if (wr) check_eq("wb_dat", 64'(rec_dat), 64'(wdata));
    end
  endtask

  // Cycles with IDLE/BUSY or no select: zero-wait OKAY and no Wishbone activity.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.hsel   = 1'($urandom_range(0, 1));
      bus.htrans = 2'($urandom_range(0, 1));
      bus.haddr  = $urandom | 32'h1000_0000;
      sl_total   = 0;
      @(negedge clk);
      check_eq("idle_ready", 64'(bus.hreadyout), 64'd1);
      check_eq("idle_resp", 64'(bus.hresp), 64'd0);
      check_eq("idle_cyc", 64'(bus.wb_cyc_o), 64'd0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.haddr  = '0;
    bus.hwdata = '0;
    bus.hwrite = 1'b0;
    bus.hsize  = 3'd0;
    bus.hburst = 3'd0;
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.hprot  = 4'd0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ready", 64'(bus.hreadyout), 64'd1);
    check_eq("rst_resp", 64'(bus.hresp), 64'd0);
    check_eq("rst_hrdata", 64'(bus.hrdata), 64'd0);
    check_eq("rst_wb", 64'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o,
                            bus.wb_adr_o, bus.wb_dat_o}), 64'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Directed cases.
    do_xfer(32'h1000_0010, 1'b0, 3'd2, '0, 0, 0, 32'hDEAD_BEEF);
    do_xfer(32'h1000_0003, 1'b1, 3'd0, 32'hAB00_0000, 2, 0, '0);
    do_xfer(32'h0000_0004, 1'b0, 3'd2, '0, 0, 0, 32'h1111_1111);
    do_xfer(32'h1000_0001, 1'b0, 3'd1, '0, 0, 0, 32'h2222_2222);
    do_xfer(32'h1000_0008, 1'b0, 3'd2, '0, 1, 0, 32'h1234_5678);
    do_xfer(32'h1000_000C, 1'b0, 3'd2, '0, 1, 1, 32'h5555_5555);
    do_xfer(32'h1000_0020, 1'b0, 3'd2, '0, 1000, 0, '0);
    do_xfer(32'h1000_0024, 1'b0, 3'd2, '0, 0, 0, 32'h0BAD_F00D);
    do_xfer(32'h1000_0028, 1'b0, 3'd2, '0, int'(TO) - 1, 0, 32'hCAFE_0001);
    do_xfer(32'h1000_0030, 1'b0, 3'd3, '0, 0, 0, '0);
    do_xfer(32'h1000_0002, 1'b1, 3'd1, 32'h7788_0000, 0, 0, '0);
    do_xfer(32'h1000_0006, 1'b1, 3'd0, 32'h0099_0000, 1, 0, '0);
    do_xfer(32'h1000_0040, 1'b0, 3'd2, '0, 0, 0, 32'hA5A5_5A5A);

    // Reset while a Wishbone cycle is waiting.
    sl_waits   = 1000;
    sl_err     = 0;
    bus.hsel   = 1'b1;
    bus.htrans = 2'b10;
    bus.haddr  = 32'h1000_0050;
    bus.hwrite = 1'b0;
    bus.hsize  = 3'd2;
    @(negedge clk);
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    @(negedge clk);
    check_eq("pre_rst_cyc", 64'(bus.wb_cyc_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_cyc", 64'({bus.wb_cyc_o, bus.wb_stb_o}), 64'd0);
    check_eq("mid_rst_ready", 64'(bus.hreadyout), 64'd1);
    check_eq("mid_rst_hrdata", 64'(bus.hrdata), 64'd0);
    exp_hrdata = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back read, write, read.
    do_xfer(32'h1000_0060, 1'b0, 3'd2, '0, 0, 0, 32'h0101_0101);
    do_xfer(32'h1000_0064, 1'b1, 3'd2, 32'h0202_0202, 0, 0, '0);
    do_xfer(32'h1000_0068, 1'b0, 3'd2, '0, 1, 0, 32'h0303_0303);
    idle_cycles(1);

    // Random traffic.
    for (int t = 0; t < 150; t++) begin
      logic [31:0] addr;
      logic [2:0]  size;
      int          r;
      r    = $urandom_range(0, 9);
      size = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'd3;
      addr = $urandom;
      addr[28] = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) < 7) addr[1:0] = (size == 3'd1) ? {addr[1], 1'b0} :
                                                (size == 3'd0) ? addr[1:0] : 2'b00;
      do_xfer(addr, 1'($urandom_range(0, 1)), size, $urandom, $urandom_range(0, 5),
              ($urandom_range(0, 9) == 0), $urandom);
      idle_cycles($urandom_range(0, 2));
    end

    check_eq("wb_stable", 64'(unstable), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
